// File: rtl/mem_pkg.sv
// Shared constants for the CPU memory subsystem: default widths and the
// DM word indices mirrored by the optional debug taps.
package mem_pkg;

   // Default word width and address widths of the three memories
   localparam int DEF_DATA_W = 32;
   localparam int DEF_MEM_AW = 14;
   localparam int DEF_IM_AW  = 10;
   localparam int DEF_DM_AW  = 12;

   // DM words mirrored by the debug taps
   localparam int NUM_DM_TAPS = 4;
   localparam int DM_TAP_IDX_0 = 0;
   localparam int DM_TAP_IDX_1 = 8;
   localparam int DM_TAP_IDX_2 = 19;
   localparam int DM_TAP_IDX_3 = 23;

   // True when a DM write at addr lands on the given tap index
   function automatic logic dm_tap_hit(input logic [DEF_DM_AW-1:0] addr,
                                       input int idx);
      return addr == DEF_DM_AW'(idx);
   endfunction

endpackage

// File: rtl/sp_sync_ram.sv
// Generic synchronous single-port RAM with registered read.
// Write beats read when both strobes are high; dout then holds.
// Reset (active low, synchronous) clears dout and blocks any access that
// cycle; array contents are never cleared.
module sp_sync_ram #(
   parameter int W  = 32,
   parameter int AW = 10
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          rd,
   input  logic          wr,
   input  logic [AW-1:0] addr,
   input  logic [W-1:0]  din,
   output logic [W-1:0]  dout
);

   localparam int DEPTH = 1 << AW;

   logic [W-1:0] ram [0:DEPTH-1];
   logic [W-1:0] dout_reg;
   logic         do_write;
   logic         do_read;

   // Decode the access for this cycle; reset suppresses both
   always_comb begin
      do_write = 1'b0;
      do_read  = 1'b0;
      if (rst && en) begin
         do_write = wr;
         do_read  = rd && !wr;
      end
   end

   // Array write port, kept free of reset so it maps onto block RAM
   always_ff @(posedge clk) begin
      if (do_write)
         ram[addr] <= din;
   end

   // Registered read data; old contents on a same-cycle write are not forwarded
   always_ff @(posedge clk) begin
      if (!rst)
         dout_reg <= '0;
      else if (do_read)
         dout_reg <= ram[addr];
   end

   assign dout = dout_reg;

endmodule

// File: rtl/inst_data_mem_subsys.sv
// Memory subsystem for the multi-cycle CPU: main/boot memory, instruction
// memory and data memory. The IM write data is the registered main-memory
// read output, so a boot copy is a main read followed by an IM write.
// Optional build macro: MEM_DEBUG_TAPS_EN adds internal mirrors of DM
// words 0, 8, 19 and 23 (dm_word_0, dm_word_8, dm_word_19, dm_word_23).
module inst_data_mem_subsys
   import mem_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int MEM_AW = DEF_MEM_AW,
   parameter int IM_AW  = DEF_IM_AW,
   parameter int DM_AW  = DEF_DM_AW
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_en,
   input  logic              mem_rd,
   input  logic              mem_wr,
   input  logic [MEM_AW-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_din,
   output logic [DATA_W-1:0] mem_dout,
   input  logic              im_en,
   input  logic              im_rd,
   input  logic              im_wr,
   input  logic [IM_AW-1:0]  im_addr,
   output logic [DATA_W-1:0] im_dout,
   input  logic              dm_en,
   input  logic              dm_rd,
   input  logic              dm_wr,
   input  logic [DM_AW-1:0]  dm_addr,
   input  logic [DATA_W-1:0] dm_din,
   output logic [DATA_W-1:0] dm_dout
);

   // Main program/boot memory
   sp_sync_ram #(.W(DATA_W), .AW(MEM_AW)) u_main_mem (
      .clk  (clk),
      .rst  (rst),
      .en   (mem_en),
      .rd   (mem_rd),
      .wr   (mem_wr),
      .addr (mem_addr),
      .din  (mem_din),
      .dout (mem_dout)
   );

   // Instruction memory, loaded from the main-memory read register
   sp_sync_ram #(.W(DATA_W), .AW(IM_AW)) u_inst_mem (
      .clk  (clk),
      .rst  (rst),
      .en   (im_en),
      .rd   (im_rd),
      .wr   (im_wr),
      .addr (im_addr),
      .din  (mem_dout),
      .dout (im_dout)
   );

   // Data memory
   sp_sync_ram #(.W(DATA_W), .AW(DM_AW)) u_data_mem (
      .clk  (clk),
      .rst  (rst),
      .en   (dm_en),
      .rd   (dm_rd),
      .wr   (dm_wr),
      .addr (dm_addr),
      .din  (dm_din),
      .dout (dm_dout)
   );

`ifdef MEM_DEBUG_TAPS_EN
   logic [DATA_W-1:0] dm_word_0;
   logic [DATA_W-1:0] dm_word_8;
   logic [DATA_W-1:0] dm_word_19;
   logic [DATA_W-1:0] dm_word_23;
   logic              dm_tap_wr;
   logic [DM_AW-1:0]  dm_tap_addr;

   // A tap only follows writes the array itself accepts
   assign dm_tap_wr   = dm_en && dm_wr;
   assign dm_tap_addr = dm_addr;

   // Mirror the tapped DM words on the same edge as the array write
   always_ff @(posedge clk) begin
      if (!rst) begin
         dm_word_0  <= '0;
         dm_word_8  <= '0;
         dm_word_19 <= '0;
         dm_word_23 <= '0;
      end else if (dm_tap_wr) begin
         if (dm_tap_addr == DM_AW'(DM_TAP_IDX_0)) dm_word_0  <= dm_din;
         if (dm_tap_addr == DM_AW'(DM_TAP_IDX_1)) dm_word_8  <= dm_din;
         if (dm_tap_addr == DM_AW'(DM_TAP_IDX_2)) dm_word_19 <= dm_din;
         if (dm_tap_addr == DM_AW'(DM_TAP_IDX_3)) dm_word_23 <= dm_din;
      end
   end
`endif

endmodule

// File: tb/tb_inst_data_mem_subsys.sv
// Directed, table-driven bench for inst_data_mem_subsys. One line is printed
// per applied transaction; each vector drives one memory for one cycle.
module tb_inst_data_mem_subsys;

   localparam int DATA_W = 32;
   localparam int MEM_AW = 14;
   localparam int IM_AW  = 10;
   localparam int DM_AW  = 12;

   localparam int SEL_MAIN = 0;
   localparam int SEL_IM   = 1;
   localparam int SEL_DM   = 2;

   logic              clk;
   logic              rst;
   logic              mem_en, mem_rd, mem_wr;
   logic [MEM_AW-1:0] mem_addr;
   logic [DATA_W-1:0] mem_din, mem_dout;
   logic              im_en, im_rd, im_wr;
   logic [IM_AW-1:0]  im_addr;
   logic [DATA_W-1:0] im_dout;
   logic              dm_en, dm_rd, dm_wr;
   logic [DM_AW-1:0]  dm_addr;
   logic [DATA_W-1:0] dm_din, dm_dout;

   inst_data_mem_subsys dut (
      .clk      (clk),
      .rst      (rst),
      .mem_en   (mem_en),
      .mem_rd   (mem_rd),
      .mem_wr   (mem_wr),
      .mem_addr (mem_addr),
      .mem_din  (mem_din),
      .mem_dout (mem_dout),
      .im_en    (im_en),
      .im_rd    (im_rd),
      .im_wr    (im_wr),
      .im_addr  (im_addr),
      .im_dout  (im_dout),
      .dm_en    (dm_en),
      .dm_rd    (dm_rd),
      .dm_wr    (dm_wr),
      .dm_addr  (dm_addr),
      .dm_din   (dm_din),
      .dm_dout  (dm_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          sel;
      logic        en;
      logic        rd;
      logic        wr;
      logic [13:0] addr;
      logic [31:0] din;
      logic [31:0] exp;
   } vec_t;

   localparam int NV = 23;
   vec_t vecs [NV];

   int n_checks;
   int n_errors;

   logic [31:0] exp_mem, exp_im, exp_dm;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %08h expected %08h", name, act, req);
      end
   endtask

   task automatic idle_inputs();
      mem_en = 0; mem_rd = 0; mem_wr = 0; mem_addr = '0; mem_din = '0;
      im_en  = 0; im_rd  = 0; im_wr  = 0; im_addr  = '0;
      dm_en  = 0; dm_rd  = 0; dm_wr  = 0; dm_addr  = '0; dm_din  = '0;
   endtask

   // Drive one vector for one clock with the given reset level, sample #1 after the edge
   task automatic apply(input vec_t v, input logic rst_val);
      @(negedge clk);
      idle_inputs();
      rst = rst_val;
      case (v.sel)
         SEL_MAIN: begin
            mem_en = v.en; mem_rd = v.rd; mem_wr = v.wr;
            mem_addr = v.addr; mem_din = v.din;
         end
         SEL_IM: begin
            im_en = v.en; im_rd = v.rd; im_wr = v.wr;
            im_addr = v.addr[IM_AW-1:0];
         end
         default: begin
            dm_en = v.en; dm_rd = v.rd; dm_wr = v.wr;
            dm_addr = v.addr[DM_AW-1:0]; dm_din = v.din;
         end
      endcase
      @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      apply(v, 1'b1);
      case (v.sel)
         SEL_MAIN: exp_mem = v.exp;
         SEL_IM:   exp_im  = v.exp;
         default:  exp_dm  = v.exp;
      endcase
      $display("%s sel=%0d en=%0d rd=%0d wr=%0d addr=%0d din=%08h -> mem=%08h im=%08h dm=%08h",
               tag, v.sel, v.en, v.rd, v.wr, v.addr, v.din, mem_dout, im_dout, dm_dout);
      chk({tag, " mem_dout"}, mem_dout, exp_mem);
      chk({tag, " im_dout"},  im_dout,  exp_im);
      chk({tag, " dm_dout"},  dm_dout,  exp_dm);
   endtask

   vec_t v;

   initial begin
      n_checks = 0;
      n_errors = 0;

      //             sel       en rd wr addr   din            expected dout of sel
      vecs[0]  = '{SEL_DM,   1, 0, 1, 14'd0,  32'h0000_00C8, 32'h0000_0000};
      vecs[1]  = '{SEL_DM,   1, 1, 0, 14'd0,  32'h0,         32'h0000_00C8};
      vecs[2]  = '{SEL_DM,   1, 0, 1, 14'd8,  32'h8000_000C, 32'h0000_00C8};
      vecs[3]  = '{SEL_DM,   1, 1, 0, 14'd8,  32'h0,         32'h8000_000C};
      vecs[4]  = '{SEL_DM,   1, 0, 1, 14'd19, 32'h0000_01F4, 32'h8000_000C};
      vecs[5]  = '{SEL_DM,   1, 1, 0, 14'd19, 32'h0,         32'h0000_01F4};
      vecs[6]  = '{SEL_DM,   1, 1, 1, 14'd19, 32'h0000_0064, 32'h0000_01F4};
      vecs[7]  = '{SEL_DM,   1, 1, 0, 14'd19, 32'h0,         32'h0000_0064};
      vecs[8]  = '{SEL_DM,   0, 1, 1, 14'd0,  32'hDEAD_BEEF, 32'h0000_0064};
      vecs[9]  = '{SEL_DM,   1, 1, 0, 14'd0,  32'h0,         32'h0000_00C8};
      vecs[10] = '{SEL_DM,   1, 0, 0, 14'd8,  32'h0,         32'h0000_00C8};
      vecs[11] = '{SEL_MAIN, 1, 0, 1, 14'd5,  32'h1234_5678, 32'h0000_0000};
      vecs[12] = '{SEL_MAIN, 1, 0, 1, 14'd6,  32'hA5A5_A5A5, 32'h0000_0000};
      vecs[13] = '{SEL_MAIN, 1, 1, 0, 14'd6,  32'h0,         32'hA5A5_A5A5};
      vecs[14] = '{SEL_MAIN, 0, 1, 1, 14'd5,  32'h0,         32'hA5A5_A5A5};
      vecs[15] = '{SEL_MAIN, 1, 1, 0, 14'd5,  32'h0,         32'h1234_5678};
      vecs[16] = '{SEL_IM,   1, 0, 1, 14'd3,  32'h0,         32'h0000_0000};
      vecs[17] = '{SEL_IM,   1, 1, 0, 14'd3,  32'h0,         32'h1234_5678};
      vecs[18] = '{SEL_MAIN, 1, 1, 0, 14'd6,  32'h0,         32'hA5A5_A5A5};
      vecs[19] = '{SEL_IM,   1, 0, 1, 14'd4,  32'h0,         32'h1234_5678};
      vecs[20] = '{SEL_IM,   1, 1, 0, 14'd4,  32'h0,         32'hA5A5_A5A5};
      vecs[21] = '{SEL_IM,   0, 1, 1, 14'd3,  32'h0,         32'hA5A5_A5A5};
      vecs[22] = '{SEL_IM,   1, 1, 0, 14'd3,  32'h0,         32'h1234_5678};

      idle_inputs();
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      $display("reset: mem=%08h im=%08h dm=%08h", mem_dout, im_dout, dm_dout);
      chk("reset mem_dout", mem_dout, 32'h0);
      chk("reset im_dout",  im_dout,  32'h0);
      chk("reset dm_dout",  dm_dout,  32'h0);
      exp_mem = 32'h0;
      exp_im  = 32'h0;
      exp_dm  = 32'h0;

      for (int i = 0; i < NV; i++)
         run_vec(vecs[i], $sformatf("vec%0d", i));

      // Reset with reads pending on all three memories clears every dout
      v = '{SEL_DM, 1, 0, 1, 14'd8, 32'h0000_012C, exp_dm};
      run_vec(v, "rst_seq_wr");
      v = '{SEL_DM, 1, 1, 0, 14'd8, 32'h0, 32'h0000_012C};
      run_vec(v, "rst_seq_rd");
      @(negedge clk);
      idle_inputs();
      rst = 1'b0;
      mem_en = 1; mem_rd = 1; mem_addr = 14'd5;
      im_en  = 1; im_rd  = 1; im_addr  = 10'd3;
      dm_en  = 1; dm_rd  = 1; dm_wr = 1; dm_addr = 12'd8; dm_din = 32'hFFFF_FFFF;
      @(posedge clk);
      #1;
      $display("rst_pulse: mem=%08h im=%08h dm=%08h", mem_dout, im_dout, dm_dout);
      chk("rst_pulse mem_dout", mem_dout, 32'h0);
      chk("rst_pulse im_dout",  im_dout,  32'h0);
      chk("rst_pulse dm_dout",  dm_dout,  32'h0);
      exp_mem = 32'h0;
      exp_im  = 32'h0;
      exp_dm  = 32'h0;
      // Contents survive reset, and the write under reset was dropped
      v = '{SEL_DM, 1, 1, 0, 14'd8, 32'h0, 32'h0000_012C};
      run_vec(v, "post_rst_dm");
      v = '{SEL_IM, 1, 1, 0, 14'd3, 32'h0, 32'h1234_5678};
      run_vec(v, "post_rst_im");

`ifdef MEM_DEBUG_TAPS_EN
      // Tap follows the DM write on the same edge and clears on reset
      v = '{SEL_DM, 1, 0, 1, 14'd23, 32'h0000_0064, exp_dm};
      run_vec(v, "tap23_wr");
      chk("tap dm_word_23", dut.dm_word_23, 32'h0000_0064);
      chk("tap dm_word_8",  dut.dm_word_8,  32'h0);
      v = '{SEL_DM, 0, 0, 1, 14'd23, 32'h0000_0077, exp_dm};
      run_vec(v, "tap23_gated");
      chk("tap dm_word_23 gated", dut.dm_word_23, 32'h0000_0064);
`endif

      @(negedge clk);
      idle_inputs();
      rst = 1'b1;
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/inst_data_mem_subsys.md
Name: inst_data_mem_subsys

Overview:
- Memory subsystem for the multi-cycle CPU. It holds three synchronous single-port RAMs:
  - main program/boot memory (MEMORY role);
  - instruction memory (IM role);
  - data memory (DM role).
- The IM write port is fed internally from the main-memory read output. The boot loader copies a word with a main-memory read followed by an IM write.
- The CPU core drives all enables and addresses. The subsystem has no internal sequencing.

Parameters:
- DATA_W, 32, word width of all three memories.
- MEM_AW, 14, main memory address width; depth 2**MEM_AW.
- IM_AW, 10, instruction memory address width; depth 2**IM_AW.
- DM_AW, 12, data memory address width; depth 2**DM_AW (4096).

Ports:
- clk  in  1  single clock; all activity on the rising edge.
- rst  in  1  synchronous active-low reset.
- mem_en  in  1  main memory enable.
- mem_rd  in  1  main memory read strobe.
- mem_wr  in  1  main memory write strobe.
- mem_addr  in  MEM_AW  main memory word address.
- mem_din  in  DATA_W  main memory write data.
- mem_dout  out  DATA_W  main memory registered read data; also the IM write data.
- im_en  in  1  IM enable.
- im_rd  in  1  IM fetch strobe.
- im_wr  in  1  IM write strobe; data is taken from mem_dout.
- im_addr  in  IM_AW  IM word address.
- im_dout  out  DATA_W  registered instruction.
- dm_en  in  1  DM enable.
- dm_rd  in  1  DM read strobe.
- dm_wr  in  1  DM write strobe.
- dm_addr  in  DM_AW  DM word address.
- dm_din  in  DATA_W  DM write data.
- dm_dout  out  DATA_W  registered DM read data.

Behaviour:
- Reset is sampled at the rising clk edge while rst==0.
  - mem_dout, im_dout and dm_dout all become 0.
  - Array contents are not modified. Main memory may be preloaded by simulation file load.
  - Reset overrides any read or write in the same cycle.
- Each of the three memories behaves identically and independently on a rising edge with rst==1:
  - en==0: no access; dout holds its value.
  - en==1, wr==1: array[addr] <= write data. Write has priority over read; dout holds.
  - en==1, wr==0, rd==1: dout <= array[addr]. Read latency is exactly 1 cycle.
  - en==1, rd==0, wr==0: dout holds.
- IM write data is the current mem_dout value, i.e. the value registered by the previous main-memory read.
  - A copy is: main read in cycle N, then IM write in cycle N+1 or later.
- A read in the cycle after a write to the same address returns the new data.
- There is no read-during-write forwarding within one cycle.
- Addresses are word addresses, fully decoded; every address is in range, with no wrap logic needed.
- All outputs are registers; no combinational path from inputs to outputs.

Optional Feature:
- MEM_DEBUG_TAPS_EN defined:
  - DM exposes internal regs dm_word_0, dm_word_8, dm_word_19 and dm_word_23 that mirror DM words 0, 8, 19 and 23.
  - They are updated on the same edge as the array write and cleared by reset.
  - This gives simulators lacking array visibility a way to inspect these words.
- Not defined: these regs do not exist. Ports and functional behaviour are identical either way.

Decomposition:
- Shared package mem_pkg holds:
  - DATA_W, MEM_AW, IM_AW and DM_AW defaults;
  - the debug tap index constants (0, 8, 19, 23).
- One generic sub-module sp_sync_ram, parameterised by width and address width, with en/rd/wr/addr/din/dout and the priority rules above.
- It is instantiated three times. The top wires IM din to mem_dout.

Test Plan:
- DM write/read: dm_en=1, dm_wr=1, addr 0, din 0x000000C8; next cycle dm_rd=1 at addr 0 -> dm_dout=0x000000C8 one cycle later. Repeat at addr 8 with 0x8000000C -> 0x8000000C.
- Boot copy: preload main memory word 5 = 0x12345678; mem_rd at 5; next cycle im_wr at im_addr 3; then im_rd at 3 -> im_dout=0x12345678.
- Priority: DM addr 19 holds 0x1F4; rd=1, wr=1 with din 0x64 -> dm_dout unchanged that cycle; a later read returns 0x64.
- Enable gating: en=0 with rd=1 and wr=1 -> neither array nor dout changes. Verify on all three memories.
- Reset: after a read gives dm_dout=0x12C, assert rst=0 for one edge -> all douts 0. Contents are preserved: re-reading DM addr 8 gives 0x12C.
- Debug taps (MEM_DEBUG_TAPS_EN set): write 0x64 to DM addr 23 -> dm_word_23=0x64 on the same edge.
